iob_rr_arbiter: RTL and testbench

- Shares one IOb native subordinate, such as a CSR bank or the simulation UUT, among N_MANAGERS IOb native managers.
- Uses round-robin arbitration with exactly one outstanding transaction.
- Holds the grant from request acceptance until write acknowledge or read data return, then routes ready/rvalid/rdata back to the granted manager.
- Sits between the bus managers (CPU, DMA, testbench driver) and the shared subordinate.

---
 rtl/iob_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_iob_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : iob_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one IOb subordinate among N managers,
//             one outstanding transaction at a time.
//  Revision : 1.0
// ============================================================================
module iob_rr_arbiter #(
    parameter int N_MANAGERS = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                           clk_i,
    input  logic                           arst_n_i,
    input  logic                           cke_i,
    input  logic [N_MANAGERS-1:0]          m_iob_valid_i,
    input  logic [N_MANAGERS*ADDR_W-1:0]   m_iob_addr_i,
    input  logic [N_MANAGERS*DATA_W-1:0]   m_iob_wdata_i,
    input  logic [N_MANAGERS*DATA_W/8-1:0] m_iob_wstrb_i,
    output logic [N_MANAGERS-1:0]          m_iob_ready_o,
    output logic [N_MANAGERS-1:0]          m_iob_rvalid_o,
    output logic [DATA_W-1:0]              m_iob_rdata_o,
    output logic                           s_iob_valid_o,
    output logic [ADDR_W-1:0]              s_iob_addr_o,
    output logic [DATA_W-1:0]              s_iob_wdata_o,
    output logic [DATA_W/8-1:0]            s_iob_wstrb_o,
    input  logic                           s_iob_ready_i,
    input  logic                           s_iob_rvalid_i,
    input  logic [DATA_W-1:0]              s_iob_rdata_i
);

    localparam int GRANT_W = (N_MANAGERS > 1) ? $clog2(N_MANAGERS) : 1;
    localparam int STRB_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t               r_state;
    logic [GRANT_W-1:0]   r_grant;
    logic [GRANT_W-1:0]   r_last;

    logic [GRANT_W-1:0]   w_next_grant;
    logic [GRANT_W-1:0]   w_idx;
    logic                 w_found;
    logic                 w_any_req;
    logic                 w_sel_valid;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [STRB_W-1:0]    w_sel_wstrb;
    logic                 w_sel_read;
    logic                 w_in_access;
    logic                 w_in_wait;
    logic                 w_accept;

    assign w_any_req = |m_iob_valid_i;

    // First requester found when scanning upward from the one after the last grantee.
    always_comb begin
        w_next_grant = r_last;
        w_idx        = '0;
        w_found      = 1'b0;
        for (int i = 1; i <= N_MANAGERS; i++) begin
            w_idx = GRANT_W'((int'(r_last) + i) % N_MANAGERS);
            if (!w_found && m_iob_valid_i[w_idx]) begin
                w_next_grant = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    assign w_sel_valid = m_iob_valid_i[r_grant];
    assign w_sel_addr  = m_iob_addr_i[int'(r_grant)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = m_iob_wdata_i[int'(r_grant)*DATA_W +: DATA_W];
    assign w_sel_wstrb = m_iob_wstrb_i[int'(r_grant)*STRB_W +: STRB_W];
    assign w_sel_read  = ~|w_sel_wstrb;

    assign w_in_access = (r_state == ACCESS);
    assign w_in_wait   = (r_state == WAIT_RD);
    assign w_accept    = w_in_access & w_sel_valid & s_iob_ready_i;

    // Request path is only driven while a grant is in its access phase.
    assign s_iob_valid_o = w_in_access & w_sel_valid;
    assign s_iob_addr_o  = w_in_access ? w_sel_addr  : '0;
    assign s_iob_wdata_o = w_in_access ? w_sel_wdata : '0;
    assign s_iob_wstrb_o = w_in_access ? w_sel_wstrb : '0;

    assign m_iob_rdata_o = s_iob_rdata_i;

    always_comb begin
        m_iob_ready_o  = '0;
        m_iob_rvalid_o = '0;
        if (w_in_access) begin
            m_iob_ready_o[r_grant] = s_iob_ready_i;
            if (w_accept && w_sel_read) begin
                m_iob_rvalid_o[r_grant] = s_iob_rvalid_i;
            end
        end
        if (w_in_wait) begin
            m_iob_rvalid_o[r_grant] = s_iob_rvalid_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GRANT_W'(N_MANAGERS - 1);
        end else if (cke_i) begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A withdrawn request releases the bus without counting as served.
                    if (!w_sel_valid) begin
                        r_state <= IDLE;
                    end else if (s_iob_ready_i) begin
                        if (!w_sel_read || s_iob_rvalid_i) begin
                            r_state <= IDLE;
                            r_last  <= r_grant;
                        end else begin
                            r_state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (s_iob_rvalid_i) begin
                        r_state <= IDLE;
                        r_last  <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_rr_arbiter
//  Purpose  : Directed self-checking bench for iob_rr_arbiter (4 managers).
//  Revision : 1.0
// ============================================================================
module tb_iob_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk    = 1'b0;
    logic            arst_n = 1'b0;
    logic            cke    = 1'b1;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    iob_rr_arbiter #(.N_MANAGERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .cke_i          (cke),
        .m_iob_valid_i  (m_valid),
        .m_iob_addr_i   (m_addr),
        .m_iob_wdata_i  (m_wdata),
        .m_iob_wstrb_i  (m_wstrb),
        .m_iob_ready_o  (m_ready),
        .m_iob_rvalid_o (m_rvalid),
        .m_iob_rdata_o  (m_rdata),
        .s_iob_valid_o  (s_valid),
        .s_iob_addr_o   (s_addr),
        .s_iob_wdata_o  (s_wdata),
        .s_iob_wstrb_o  (s_wstrb),
        .s_iob_ready_i  (s_ready),
        .s_iob_rvalid_i (s_rvalid),
        .s_iob_rdata_i  (s_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner is the manager holding the bus (-1 = free),
    // data_due marks an accepted read still waiting for its data.
    int owner     = -1;
    int last_done = N - 1;
    bit data_due  = 1'b0;
    int nxt_owner = -1;
    int nxt_last  = N - 1;
    bit nxt_due   = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rvalid;
        bit           e_sval;
        bit           rd;
        int           k;
        if (arst_n) begin
            e_ready   = '0;
            e_rvalid  = '0;
            e_sval    = 1'b0;
            rd        = 1'b0;
            k         = 0;
            nxt_owner = owner;
            nxt_last  = last_done;
            nxt_due   = data_due;
            if (owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    k = (last_done + i) % N;
                    if (nxt_owner < 0 && m_valid[k]) nxt_owner = k;
                end
            end else begin
                rd = (m_wstrb[owner*SW +: SW] == '0);
                if (data_due) begin
                    e_rvalid[owner] = s_rvalid;
                    if (s_rvalid) begin
                        nxt_owner = -1;
                        nxt_last  = owner;
                        nxt_due   = 1'b0;
                    end
                end else begin
                    e_sval         = m_valid[owner];
                    e_ready[owner] = s_ready;
                    if (!m_valid[owner]) begin
                        nxt_owner = -1;
                    end else if (s_ready) begin
                        if (rd) e_rvalid[owner] = s_rvalid;
                        if (!rd || s_rvalid) begin
                            nxt_owner = -1;
                            nxt_last  = owner;
                        end else begin
                            nxt_due = 1'b1;
                        end
                    end
                end
            end
            check("cyc_s_valid", 64'(s_valid), 64'(e_sval));
            check("cyc_m_ready", 64'(m_ready), 64'(e_ready));
            check("cyc_m_rvalid", 64'(m_rvalid), 64'(e_rvalid));
            check("cyc_m_rdata", 64'(m_rdata), 64'(s_rdata));
            if (e_sval) begin
                check("cyc_s_addr", 64'(s_addr), 64'(m_addr[owner*AW +: AW]));
                check("cyc_s_wdata", 64'(s_wdata), 64'(m_wdata[owner*DW +: DW]));
                check("cyc_s_wstrb", 64'(s_wstrb), 64'(m_wstrb[owner*SW +: SW]));
            end
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            owner     <= -1;
            last_done <= N - 1;
            data_due  <= 1'b0;
        end else if (cke) begin
            owner     <= nxt_owner;
            last_done <= nxt_last;
            data_due  <= nxt_due;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input bit v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        m_valid[k]          = v;
        m_addr[k*AW +: AW]  = a;
        m_wdata[k*DW +: DW] = d;
        m_wstrb[k*SW +: SW] = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int grants[$];

    initial begin
        int gi;
        m_valid  = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        check("rst_s_addr", 64'(s_addr), 64'd0);
        arst_n = 1'b1;

        // Single write from manager 1
        step();
        req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        s_ready = 1'b1;
        #1 check("t1_idle_no_valid", 64'(s_valid), 64'd0);
        step();
        #1;
        check("t1_s_valid", 64'(s_valid), 64'd1);
        check("t1_ready", 64'(m_ready), 64'b0010);
        check("t1_addr", 64'(s_addr), 64'h10);
        check("t1_wdata", 64'(s_wdata), 64'hDEADBEEF);
        step();
        req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("t1_back_idle_valid", 64'(s_valid), 64'd0);
        check("t1_back_idle_ready", 64'(m_ready), 64'd0);

        // Read from manager 0, ready after 2 cycles, data 3 cycles later
        req(0, 1'b1, 32'h4, 32'h0, 4'h0);
        s_ready = 1'b0;
        step();
        #1 check("t2_access", 64'(s_valid), 64'd1);
        step();
        step();
        s_ready = 1'b1;
        #1 check("t2_ready", 64'(m_ready), 64'b0001);
        step();
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ready = 1'b0;
        req(1, 1'b1, 32'h8, 32'h55, 4'hF);
        #1 check("t2_wait_no_valid", 64'(s_valid), 64'd0);
        step();
        step();
        s_rvalid = 1'b1;
        s_rdata  = 32'h12345678;
        #1;
        check("t2_rvalid", 64'(m_rvalid), 64'b0001);
        check("t2_rdata", 64'(m_rdata), 64'h12345678);
        check("t2_wait_no_valid2", 64'(s_valid), 64'd0);
        step();
        s_rvalid = 1'b0;
        s_ready  = 1'b1;
        step();
        #1 check("t2_next_grant", 64'(m_ready), 64'b0010);
        step();
        req(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Read with ready and rvalid in the same cycle (manager 2), manager 3 queued
        req(2, 1'b1, 32'h20, 32'h0, 4'h0);
        req(3, 1'b1, 32'h30, 32'hA5A5, 4'h3);
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'hAABBCCDD;
        step();
        #1;
        check("t4_rvalid", 64'(m_rvalid), 64'b0100);
        check("t4_ready", 64'(m_ready), 64'b0100);
        check("t4_rdata", 64'(m_rdata), 64'hAABBCCDD);
        step();
        req(2, 1'b0, 32'h0, 32'h0, 4'h0);
        s_rvalid = 1'b0;
        #1 check("t4_idle_gap", 64'(s_valid), 64'd0);
        step();
        #1;
        check("t4_next_ready", 64'(m_ready), 64'b1000);
        check("t4_next_wstrb", 64'(s_wstrb), 64'h3);
        step();
        req(3, 1'b0, 32'h0, 32'h0, 4'h0);

        // Clock-enable stall while waiting for read data (manager 1)
        req(1, 1'b1, 32'h40, 32'h0, 4'h0);
        s_ready = 1'b1;
        step();
        step();
        req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ready = 1'b0;
        req(0, 1'b1, 32'h50, 32'h1, 4'hF);
        cke = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_stall_rvalid", 64'(m_rvalid), 64'd0);
            check("t5_stall_valid", 64'(s_valid), 64'd0);
            step();
        end
        cke      = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFEF00D;
        #1 check("t5_rvalid", 64'(m_rvalid), 64'b0010);
        step();
        s_rvalid = 1'b0;
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        req(2, 1'b1, 32'h60, 32'h2, 4'hF);
        step();
        #1;
        check("t6_pre_valid", 64'(s_valid), 64'd1);
        check("t6_pre_addr", 64'(s_addr), 64'h60);

        // Reset during ACCESS of manager 2
        req(0, 1'b1, 32'h70, 32'h7, 4'hF);
        s_rdata = '0;
        arst_n  = 1'b0;
        #1;
        check("t6_rst_valid", 64'(s_valid), 64'd0);
        check("t6_rst_addr", 64'(s_addr), 64'd0);
        check("t6_rst_wdata", 64'(s_wdata), 64'd0);
        check("t6_rst_wstrb", 64'(s_wstrb), 64'd0);
        check("t6_rst_ready", 64'(m_ready), 64'd0);
        check("t6_rst_rvalid", 64'(m_rvalid), 64'd0);
        step();
        step();
        arst_n  = 1'b1;
        s_ready = 1'b1;
        step();
        #1;
        check("t6_first_ready", 64'(m_ready), 64'b0001);
        check("t6_first_addr", 64'(s_addr), 64'h70);
        step();
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        req(2, 1'b0, 32'h0, 32'h0, 4'h0);

        // Round robin with all four managers writing continuously from reset
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        for (int k = 0; k < N; k++) req(k, 1'b1, AW'(32'h100 + k), DW'(k), 4'hF);
        s_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            #1;
            check("t3_onehot", 64'($countones(m_ready) <= 1), 64'd1);
            gi = -1;
            for (int b = 0; b < N; b++) if (m_ready[b]) gi = b;
            if (gi >= 0) grants.push_back(gi);
        end
        check("t3_grant_count", 64'(grants.size()), 64'd6);
        if (grants.size() == 6) begin
            check("t3_g0", 64'(grants[0]), 64'd0);
            check("t3_g1", 64'(grants[1]), 64'd1);
            check("t3_g2", 64'(grants[2]), 64'd2);
            check("t3_g3", 64'(grants[3]), 64'd3);
            check("t3_g4", 64'(grants[4]), 64'd0);
            check("t3_g5", 64'(grants[5]), 64'd1);
        end
        m_valid = '0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
